// File: rtl/pwm_pkg.sv
// Shared types and shadow-register address offsets for the multi-channel PWM.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pwm_pkg;

    // Counter shape: sawtooth or up/down triangle
    typedef enum logic {
        EDGE   = 1'b0,
        CENTER = 1'b1
    } mode_e;

    // Shadow addresses above the per-channel compare block, as offsets from N_CH
    localparam int ADDR_ARR  = 0;
    localparam int ADDR_MODE = 1;
    localparam int ADDR_DT   = 2;

    // Width of the shadow address bus for a given channel count
    function automatic int addr_width(input int n_ch);
        return $clog2(n_ch + 3);
    endfunction

endpackage

// File: rtl/pwm_multi_if.sv
// Shadow-register write port and update request for pwm_multi.
// Latency: writes land in shadow on the clock edge that samples wr_en.
// Backpressure: none; every write and request is accepted.
interface pwm_multi_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 16
);
    localparam int ADDR_W = pwm_pkg::addr_width(N_CH);

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              upd_req;

    modport master (output wr_en, output wr_addr, output wr_data, output upd_req);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data, input  upd_req);

endinterface

// File: rtl/pwm_deadtime.sv
// Splits one PWM level into a dead-time separated complementary pair.
// Latency: 1 cycle for falling edges; rising edges delayed by dt extra cycles.
// Backpressure: none; pulses shorter than dt never reach either output.
module pwm_deadtime #(
    parameter int DT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            level,
    input  logic [DT_W-1:0] dt,
    output logic            pwm,
    output logic            pwm_n
);

    logic            lvl_q;
    logic [DT_W-1:0] run;
    logic [DT_W-1:0] run_nxt;
    logic            settled;

    // Cycles the level has been stable, saturating so long plateaus stay settled
    always_comb begin
        run_nxt = run;
        if (level != lvl_q) begin
            run_nxt = '0;
        end else if (run != '1) begin
            run_nxt = run + DT_W'(1);
        end
        settled = (run_nxt >= dt);
    end

    // A side may only turn on once the level has held for dt cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_q <= 1'b0;
            run   <= '1;
            pwm   <= 1'b0;
            pwm_n <= 1'b0;
        end else begin
            lvl_q <= level;
            run   <= run_nxt;
            pwm   <= level & settled;
            pwm_n <= ~level & settled;
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// N_CH-channel PWM with shared counter, shadowed compare/period/mode, optional dead-time (PWM_DEADTIME_EN).
// Latency: pwm_o and period_o registered, one cycle after the counter value they reflect.
// Backpressure: none; shadow writes and update requests are always accepted.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 16,
    parameter int DT_W  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    pwm_multi_if.slave      bus,
    input  logic [N_CH-1:0] pol,
    output logic [N_CH-1:0] pwm_o,
    output logic            period_o,
    output logic            upd_pend_o
`ifdef PWM_DEADTIME_EN
    ,
    output logic [N_CH-1:0] pwm_n_o
`endif
);

    localparam int ADDR_W = addr_width(N_CH);
    localparam logic [ADDR_W-1:0] A_ARR  = ADDR_W'(N_CH + ADDR_ARR);
    localparam logic [ADDR_W-1:0] A_MODE = ADDR_W'(N_CH + ADDR_MODE);
`ifdef PWM_DEADTIME_EN
    localparam logic [ADDR_W-1:0] A_DT   = ADDR_W'(N_CH + ADDR_DT);
`endif

    // Shadow copies (software side) and active copies (counter side)
    logic [WIDTH-1:0] sh_cmp [N_CH];
    logic [WIDTH-1:0] sh_arr;
    mode_e            sh_mode;
    logic [WIDTH-1:0] cmp [N_CH];
    logic [WIDTH-1:0] arr;
    mode_e            mode;
`ifdef PWM_DEADTIME_EN
    logic [DT_W-1:0]  sh_dt;
    logic [DT_W-1:0]  dt;
`endif

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             dir_down;
    logic             dn_nxt;
    logic             pend;
    logic             evt;
    logic             xfer;
    logic [N_CH-1:0]  raw;
    logic [N_CH-1:0]  lvl;

    // Shadow register file; a write in a transfer cycle still lands here only
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) sh_cmp[i] <= '0;
            sh_arr  <= '1;
            sh_mode <= EDGE;
`ifdef PWM_DEADTIME_EN
            sh_dt   <= '0;
`endif
        end else if (bus.wr_en) begin
            for (int i = 0; i < N_CH; i++) begin
                if (bus.wr_addr == ADDR_W'(i)) sh_cmp[i] <= bus.wr_data;
            end
            if (bus.wr_addr == A_ARR)  sh_arr  <= bus.wr_data;
            if (bus.wr_addr == A_MODE) sh_mode <= mode_e'(bus.wr_data[0]);
`ifdef PWM_DEADTIME_EN
            // dead-time is the low DT_W bits of the data word (DT_W <= WIDTH)
            if (bus.wr_addr == A_DT)   sh_dt   <= bus.wr_data[DT_W-1:0];
`endif
        end
    end

    // Period event marks the last cycle of a period; a transfer rides on it
    always_comb begin
        evt = 1'b0;
        if (en) begin
            if (arr == '0)        evt = 1'b1;
            else if (mode == EDGE) evt = (cnt == arr);
            else                   evt = dir_down && (cnt == '0);
        end
        // a request arriving in the event cycle is honoured in that same event
        xfer = evt && (pend || bus.upd_req);
    end

    // Active registers reload from shadow only at a period event
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) cmp[i] <= '0;
            arr  <= '1;
            mode <= EDGE;
`ifdef PWM_DEADTIME_EN
            dt   <= '0;
`endif
        end else if (xfer) begin
            for (int i = 0; i < N_CH; i++) cmp[i] <= sh_cmp[i];
            arr  <= sh_arr;
            mode <= sh_mode;
`ifdef PWM_DEADTIME_EN
            dt   <= sh_dt;
`endif
        end
    end

    // Next counter value; after a transfer the new period/mode shape it
    always_comb begin
        cnt_nxt = cnt;
        dn_nxt  = dir_down;
        if (!en) begin
            cnt_nxt = '0;
            dn_nxt  = 1'b0;
        end else if (xfer) begin
            // mode switch or edge wrap restarts at 0; center continues up from 1
            dn_nxt = 1'b0;
            if (sh_mode != mode || sh_mode == EDGE || sh_arr == '0) cnt_nxt = '0;
            else                                                    cnt_nxt = WIDTH'(1);
        end else if (arr == '0) begin
            cnt_nxt = '0;
            dn_nxt  = 1'b0;
        end else if (mode == EDGE) begin
            cnt_nxt = (cnt == arr) ? '0 : cnt + WIDTH'(1);
            dn_nxt  = 1'b0;
        end else if (!dir_down) begin
            // ARR is visited once, then the count turns down
            if (cnt == arr) begin
                cnt_nxt = cnt - WIDTH'(1);
                dn_nxt  = 1'b1;
            end else begin
                cnt_nxt = cnt + WIDTH'(1);
            end
        end else begin
            // 0 is visited once, then the count turns up
            if (cnt == '0) begin
                cnt_nxt = WIDTH'(1);
                dn_nxt  = 1'b0;
            end else begin
                cnt_nxt = cnt - WIDTH'(1);
            end
        end
    end

    // Counter and direction state
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            dir_down <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            dir_down <= dn_nxt;
        end
    end

    // Pending flag: set by request, cleared by the transfer it waits for
    always_ff @(posedge clk) begin
        if (rst)               pend <= 1'b0;
        else if (xfer)         pend <= 1'b0;
        else if (bus.upd_req)  pend <= 1'b1;
    end

    assign upd_pend_o = pend;

    // Raw compare level per channel, forced low while stopped, then polarity
    always_comb begin
        raw = '0;
        for (int i = 0; i < N_CH; i++) raw[i] = en && (cnt < cmp[i]);
        lvl = raw ^ pol;
    end

    // Period pulse aligned with the registered channel outputs
    always_ff @(posedge clk) begin
        if (rst) period_o <= 1'b0;
        else     period_o <= evt;
    end

`ifdef PWM_DEADTIME_EN
    for (genvar g = 0; g < N_CH; g++) begin : g_dt
        pwm_deadtime #(.DT_W(DT_W)) u_dt (
            .clk   (clk),
            .rst   (rst),
            .level (lvl[g]),
            .dt    (dt),
            .pwm   (pwm_o[g]),
            .pwm_n (pwm_n_o[g])
        );
    end
`else
    // Registered channel outputs
    always_ff @(posedge clk) begin
        if (rst) pwm_o <= '0;
        else     pwm_o <= lvl;
    end
`endif

endmodule

// File: tb/tb_pwm_multi.sv
// Directed self-checking bench for pwm_multi: table of configurations plus corner sequences.
// Latency: inputs driven on falling edges, outputs sampled on falling edges.
// Backpressure: n/a.
module tb_pwm_multi;

    localparam int N_CH  = 4;
    localparam int WIDTH = 8;
    localparam int DT_W  = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [N_CH-1:0] pol;
    logic [N_CH-1:0] pwm_o;
    logic            period_o;
    logic            upd_pend_o;
`ifdef PWM_DEADTIME_EN
    logic [N_CH-1:0] pwm_n_o;
`endif

    pwm_multi_if #(.N_CH(N_CH), .WIDTH(WIDTH)) bus ();

    pwm_multi #(.N_CH(N_CH), .WIDTH(WIDTH), .DT_W(DT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .bus        (bus),
        .pol        (pol),
        .pwm_o      (pwm_o),
        .period_o   (period_o),
        .upd_pend_o (upd_pend_o)
`ifdef PWM_DEADTIME_EN
        ,
        .pwm_n_o    (pwm_n_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int                arr;
        int                mode;
        logic [3:0][7:0]   cmp;
        logic [3:0]        pol;
        int                len;
        logic [3:0][7:0]   hi;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   m_len;
    int   m_hi   [4];
    int   m_nhi  [4];
    int   m_both [4];
    vec_t vec    [6];

    function automatic vec_t mk(input int arr, input int mode,
                                input int c0, input int c1, input int c2, input int c3,
                                input int p, input int len,
                                input int h0, input int h1, input int h2, input int h3);
        vec_t v;
        v.arr = arr; v.mode = mode; v.pol = 4'(p); v.len = len;
        v.cmp[0] = 8'(c0); v.cmp[1] = 8'(c1); v.cmp[2] = 8'(c2); v.cmp[3] = 8'(c3);
        v.hi[0]  = 8'(h0); v.hi[1]  = 8'(h1); v.hi[2]  = 8'(h2); v.hi[3]  = 8'(h3);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    task automatic wr(input int addr, input int data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'(addr);
        bus.wr_data = 8'(data);
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic req();
        bus.upd_req = 1'b1;
        @(negedge clk);
        bus.upd_req = 1'b0;
    endtask

    task automatic wait_pulse(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            if (period_o) seen = 1'b1;
        end
        if (!seen) timeout(name);
    endtask

    task automatic wait_xfer(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk);
            if (!upd_pend_o) done = 1'b1;
        end
        if (!done) timeout(name);
    endtask

    // One full period between two period pulses (exclusive start, inclusive end)
    task automatic measure(input string name);
        bit seen = 1'b0;
        wait_pulse(name);
        m_len = 0;
        for (int c = 0; c < 4; c++) begin
            m_hi[c] = 0; m_nhi[c] = 0; m_both[c] = 0;
        end
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            m_len++;
            for (int c = 0; c < 4; c++) begin
                m_hi[c] += int'(pwm_o[c]);
`ifdef PWM_DEADTIME_EN
                m_nhi[c]  += int'(pwm_n_o[c]);
                m_both[c] += int'(!pwm_o[c] && !pwm_n_o[c]);
`endif
            end
            if (period_o) seen = 1'b1;
        end
        if (!seen) timeout(name);
    endtask

    task automatic apply(input vec_t v);
        pol = v.pol;
        for (int c = 0; c < 4; c++) wr(c, int'(v.cmp[c]));
        wr(4, v.arr);
        wr(5, v.mode);
        req();
        wait_xfer("xfer");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end

    initial begin
        int n;
        // Edge ARR=9: duty 0,3,9,10 of 10
        vec[0] = mk(9, 0, 0, 3, 9, 10, 4'b0000, 10, 0, 3, 9, 10);
        // Same with channels 1 and 3 inverted
        vec[1] = mk(9, 0, 0, 3, 9, 10, 4'b1010, 10, 0, 7, 9, 0);
        // Center ARR=8: values 1..7 seen twice, 0 and 8 once; cnt<4 -> 7 of 16
        vec[2] = mk(8, 1, 4, 0, 9, 8, 4'b0000, 16, 7, 0, 16, 15);
        // Edge ARR=0: counter pinned at 0, event every cycle
        vec[3] = mk(0, 0, 0, 1, 1, 0, 4'b0000, 1, 0, 1, 1, 0);
        // Center ARR=1: 0,1 alternate, period 2
        vec[4] = mk(1, 1, 1, 2, 0, 1, 4'b0000, 2, 1, 2, 0, 1);
        // Edge ARR=4 with channel 0 inverted, compare above ARR is full duty
        vec[5] = mk(4, 0, 2, 5, 4, 1, 4'b0001, 5, 3, 5, 4, 1);

        rst = 1'b1; en = 1'b0; pol = '0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.upd_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pwm", int'(pwm_o), 0);
        chk("rst_period", int'(period_o), 0);
        chk("rst_pend", int'(upd_pend_o), 0);
        rst = 1'b0;
        en  = 1'b1;

        for (int i = 0; i < 6; i++) begin
            apply(vec[i]);
            measure("tbl_measure");
            chk($sformatf("tbl%0d_len", i), m_len, vec[i].len);
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("tbl%0d_hi%0d", i, c), m_hi[c], int'(vec[i].hi[c]));
`ifdef PWM_DEADTIME_EN
                chk($sformatf("tbl%0d_nhi%0d", i, c), m_nhi[c], vec[i].len - int'(vec[i].hi[c]));
`endif
            end
        end

        // Shadow write without request leaves duty alone
        apply(vec[0]);
        wr(1, 5);
        measure("sh_measure");
        chk("sh_noreq_hi1", m_hi[1], 3);
        chk("sh_noreq_pend", int'(upd_pend_o), 0);
        req();
        chk("sh_pend_set", int'(upd_pend_o), 1);
        wait_pulse("sh_pulse");
        chk("sh_pend_clr", int'(upd_pend_o), 0);
        measure("sh_measure");
        chk("sh_upd_hi1", m_hi[1], 5);

        // Write in the transfer cycle: older shadow value moves, new one waits
        wr(1, 7);
        req();
        repeat (7) @(negedge clk);
        wr(1, 2);
        chk("defer_pulse", int'(period_o), 1);
        chk("defer_pend", int'(upd_pend_o), 0);
        measure("defer_measure");
        chk("defer_hi1", m_hi[1], 7);
        req();
        wait_xfer("defer_xfer");
        measure("defer_measure");
        chk("defer_late_hi1", m_hi[1], 2);

        // Request in the event cycle transfers immediately
        wr(1, 4);
        repeat (8) @(negedge clk);
        req();
        chk("coinc_pulse", int'(period_o), 1);
        chk("coinc_pend", int'(upd_pend_o), 0);
        measure("coinc_measure");
        chk("coinc_hi1", m_hi[1], 4);

        // Stop mid-period: outputs show polarity, no events, requests still latch
        pol = 4'b0101;
        repeat (4) @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        chk("stop_pwm", int'(pwm_o), 5);
        wr(1, 6);
        req();
        n = 0;
        repeat (30) begin
            @(negedge clk);
            n += int'(period_o);
        end
        chk("stop_pulses", n, 0);
        chk("stop_pend", int'(upd_pend_o), 1);
        en = 1'b1;
        @(negedge clk);
        n = 1;
        // cnt=0 with compare {0,4,9,10}: raw 1110, xor 0101
        chk("restart_pwm", int'(pwm_o), 4'b1011);
        while (!period_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("restart_len", n, 10);
        chk("restart_pend", int'(upd_pend_o), 0);
        pol = '0;
        measure("restart_measure");
        chk("restart_hi1", m_hi[1], 6);

`ifdef PWM_DEADTIME_EN
        // Dead-time 3 on a 20-cycle period, 10 high / 10 low
        wr(6, 3);
        apply(mk(19, 0, 10, 10, 10, 10, 0, 20, 10, 10, 10, 10));
        measure("dt_measure");
        chk("dt_len", m_len, 20);
        chk("dt_hi", m_hi[0], 7);
        chk("dt_nhi", m_nhi[0], 7);
        chk("dt_gap", m_both[0], 6);
        // 2-cycle pulse is shorter than the dead-time
        wr(0, 2);
        req();
        wait_xfer("dt_xfer");
        measure("dt_measure");
        chk("dt_short_hi", m_hi[0], 0);
        chk("dt_short_nhi", m_nhi[0], 15);
        chk("dt_short_gap", m_both[0], 5);
`endif

        // Reset mid-period with a pending request and inverted outputs
        pol = 4'b1111;
        repeat (3) @(negedge clk);
        req();
        rst = 1'b1;
        @(negedge clk);
        pol = '0;
        chk("midrst_pwm", int'(pwm_o), 0);
        chk("midrst_period", int'(period_o), 0);
        chk("midrst_pend", int'(upd_pend_o), 0);
        rst = 1'b0;
        n = 0;
        repeat (100) begin
            @(negedge clk);
            n += int'(period_o) + int'(pwm_o != 4'b0000);
        end
        // ARR back to all-ones and compare back to 0: quiet for 100 cycles
        chk("midrst_quiet", n, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
